// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and default parameters
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int DATA_LENGTH_DEF = 8;
  localparam int PARITY_EN_DEF = 0;
  localparam int CLK_PER_BIT_DEF = 20;
endpackage

// File: rtl/baud_rate_RX.sv
// baud_rate_RX: mid-bit sample strobe, half a bit after restart then every full bit
module baud_rate_RX #(
  parameter int CLK_PER_BIT = uart_pkg::CLK_PER_BIT_DEF
) (
  input  logic rx_clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CLK_PER_BIT);
  logic [CW-1:0] cnt;
  logic first;
  assign tick = en & (cnt == (first ? CW'(CLK_PER_BIT / 2 - 1) : CW'(CLK_PER_BIT - 1)));
  // cycle counter wraps at every sample point; first interval is half a bit
  always_ff @(posedge rx_clk) begin
    if (rst || restart || !en) begin
      cnt <= '0;
      first <= 1'b1;
    end else if (tick) begin
      cnt <= '0;
      first <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver with optional parity and error flags
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int PARITY_EN = PARITY_EN_DEF,
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic rx_clk,
  input  logic rst,
  input  logic serialdata_in,
  input  logic parity_type,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic rx_valid,
  output logic parity_err,
  output logic frame_err,
  output logic rx_busy
);
  localparam int BW = $clog2(DATA_LENGTH + 1);
  if (CLK_PER_BIT < 4 || CLK_PER_BIT % 2 != 0) begin : g_bad_clk_per_bit
    $error("CLK_PER_BIT must be even and at least 4");
  end
  uart_state_t state_q, state_d;
  logic s1, s2, rxs, rxs_q, fall, tick, restart, par;
  logic [1:0] vld;
  logic [DATA_LENGTH-1:0] sh;
  logic [BW-1:0] bcnt;
  assign rxs = s2;
  assign fall = rxs_q & ~rxs;
  assign restart = (state_q == IDLE) & fall;
  assign rx_busy = state_q != IDLE;
  baud_rate_RX #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
    .rx_clk(rx_clk),
    .rst(rst),
    .en(rx_busy),
    .restart(restart),
    .tick(tick)
  );
  // synchronizer; rxs_q only reports high once real line data has flushed through
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      vld <= '0;
      rxs_q <= 1'b0;
    end else begin
      s1 <= serialdata_in;
      s2 <= s1;
      vld <= {vld[0], 1'b1};
      rxs_q <= rxs & vld[1];
    end
  end
  // state register
  always_ff @(posedge rx_clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state logic, advancing only on sample strobes once a frame has started
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fall ? START : IDLE;
      START:   state_d = tick ? (rxs ? IDLE : DATA) : START;
      DATA:    state_d = (tick && bcnt == BW'(DATA_LENGTH - 1)) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
      STOP:    state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // datapath: shift data LSB first, check parity, publish word and flags at the stop sample
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      data_out <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      sh <= '0;
      bcnt <= '0;
      par <= 1'b0;
    end else begin
      rx_valid <= tick && state_q == STOP;
      if (restart) begin
        bcnt <= '0;
        par <= 1'b0;
      end
      if (tick && state_q == DATA) begin
        sh <= {rxs, sh[DATA_LENGTH-1:1]};
        bcnt <= bcnt + BW'(1);
      end
      if (tick && state_q == PARITY) par <= rxs != (^sh ^ parity_type);
      if (tick && state_q == STOP) begin
        data_out <= sh;
        frame_err <= ~rxs;
        parity_err <= (PARITY_EN != 0) & par;
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed vector and corner-case checks of uart_receiver
module tb_uart_receiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, sd0, sd1, pt;
  logic [7:0] do0, do1;
  logic v0, pe0, fe0, b0, v1, pe1, fe1, b1;
  uart_receiver #(.DATA_LENGTH(8), .PARITY_EN(0), .CLK_PER_BIT(20)) dut0 (
    .rx_clk(clk), .rst(rst), .serialdata_in(sd0), .parity_type(pt),
    .data_out(do0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0), .rx_busy(b0)
  );
  uart_receiver #(.DATA_LENGTH(8), .PARITY_EN(1), .CLK_PER_BIT(20)) dut1 (
    .rx_clk(clk), .rst(rst), .serialdata_in(sd1), .parity_type(pt),
    .data_out(do1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1), .rx_busy(b1)
  );
  typedef struct {int cyc; logic [7:0] d; logic pe; logic fe;} rec_t;
  typedef struct {int sel; logic [7:0] d; logic pt; logic pb; logic sb; logic [7:0] ed; logic epe; logic efe;} vec_t;
  rec_t q0[$], q1[$];
  vec_t tv[8];
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (v0) q0.push_back('{cyc, do0, pe0, fe0});
    if (v1) q1.push_back('{cyc, do1, pe1, fe1});
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input int sel, input logic b);
    if (sel == 0) sd0 = b;
    else sd1 = b;
    idle(20);
  endtask
  task automatic send(input int sel, input logic [7:0] d, input logic pb, input logic sb);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (sel == 1) drive(sel, pb);
    drive(sel, sb);
  endtask
  initial begin
    int n, got, fc, lat;
    rec_t r;
    tv[0] = '{0, 8'h5A, 0, 0, 1, 8'h5A, 0, 0};
    tv[1] = '{1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0};
    tv[2] = '{1, 8'hA5, 0, 1, 1, 8'hA5, 1, 0};
    tv[3] = '{1, 8'hA5, 1, 1, 1, 8'hA5, 0, 0};
    tv[4] = '{0, 8'h3C, 0, 0, 0, 8'h3C, 0, 1};
    tv[5] = '{1, 8'h0F, 0, 0, 1, 8'h0F, 0, 0};
    tv[6] = '{1, 8'h07, 0, 0, 0, 8'h07, 1, 1};
    tv[7] = '{0, 8'h00, 0, 0, 1, 8'h00, 0, 0};
    rst = 1'b1; sd0 = 1'b0; sd1 = 1'b1; pt = 1'b0;
    idle(3);
    check("reset busy", b0, 0);
    check("reset valid", v0, 0);
    check("reset data", do0, 0);
    check("reset perr", pe1, 0);
    check("reset ferr", fe0, 0);
    rst = 1'b0;
    idle(300);
    check("low line at reset exit pulses", q0.size(), 0);
    check("low line at reset exit busy", b0, 0);
    sd0 = 1'b1;
    idle(40);
    for (int i = 0; i < 8; i++) begin
      pt = tv[i].pt;
      n = (tv[i].sel == 1) ? q1.size() : q0.size();
      send(tv[i].sel, tv[i].d, tv[i].pb, tv[i].sb);
      if (tv[i].sel == 1) sd1 = 1'b1;
      else sd0 = 1'b1;
      idle(40);
      got = ((tv[i].sel == 1) ? q1.size() : q0.size()) - n;
      check($sformatf("vec%0d pulses", i), got, 1);
      if (got > 0) begin
        r = (tv[i].sel == 1) ? q1[$] : q0[$];
        check($sformatf("vec%0d data", i), r.d, tv[i].ed);
        check($sformatf("vec%0d parity_err", i), r.pe, tv[i].epe);
        check($sformatf("vec%0d frame_err", i), r.fe, tv[i].efe);
      end
    end
    n = q0.size();
    sd0 = 1'b0;
    idle(5);
    sd0 = 1'b1;
    idle(3);
    check("glitch seen busy", b0, 1);
    idle(12);
    check("glitch back idle", b0, 0);
    idle(200);
    check("glitch pulses", q0.size() - n, 0);
    n = q0.size();
    send(0, 8'h3C, 0, 0);
    idle(400);
    check("break pulses", q0.size() - n, 1);
    if (q0.size() > n) begin
      check("break data", q0[n].d, 8'h3C);
      check("break frame_err", q0[n].fe, 1);
    end
    check("break busy", b0, 0);
    sd0 = 1'b1;
    idle(40);
    send(0, 8'h5A, 0, 1);
    idle(40);
    check("after break pulses", q0.size() - n, 2);
    check("after break data", q0[$].d, 8'h5A);
    check("after break frame_err", q0[$].fe, 0);
    n = q0.size();
    fc = cyc;
    send(0, 8'h01, 0, 1);
    send(0, 8'hFF, 0, 1);
    idle(40);
    check("b2b pulses", q0.size() - n, 2);
    if (q0.size() >= n + 2) begin
      check("b2b data0", q0[n].d, 8'h01);
      check("b2b data1", q0[n+1].d, 8'hFF);
      check("b2b spacing", q0[n+1].cyc - q0[n].cyc, 200);
      lat = q0[n].cyc - fc;
      if (lat < 190 || lat > 196) $display("latency out of window: %0d", lat);
      check("b2b latency window", (lat >= 190 && lat <= 196), 1);
    end
    n = q0.size();
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 1'b0 ^ i[0]);
    sd0 = 1'b0;
    idle(10);
    rst = 1'b1;
    @(negedge clk);
    check("midreset busy", b0, 0);
    check("midreset valid", v0, 0);
    check("midreset data", do0, 0);
    check("midreset data dut1", do1, 0);
    rst = 1'b0;
    sd0 = 1'b1;
    idle(60);
    check("midreset no pulse", q0.size() - n, 0);
    send(0, 8'h77, 0, 1);
    idle(40);
    check("post reset pulses", q0.size() - n, 1);
    check("post reset data", q0[$].d, 8'h77);
    check("post reset frame_err", q0[$].fe, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 8, number of data bits per frame.
REQ-002 SHALL have parameter PARITY_EN, default 0; 1 means a parity bit follows the data bits.
REQ-003 SHALL have parameter CLK_PER_BIT, default 20, rx_clk cycles per serial bit, and SHALL require it to be even and at least 4.
REQ-004 SHALL have port rx_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port serialdata_in, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port parity_type, input, 1 bit: 0 means expected parity = XOR of data; 1 means expected parity = inverted XOR of data.
REQ-008 SHALL have port data_out, output, DATA_LENGTH bits: last received word.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-010 SHALL have port parity_err, output, 1 bit: status for the frame flagged by rx_valid.
REQ-011 SHALL have port frame_err, output, 1 bit: status for the frame flagged by rx_valid.
REQ-012 SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL pass serialdata_in through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-015 IDLE: on rxs falling edge (previous 1, current 0), SHALL clear the bit counter and go to START; a line already low at reset exit SHALL NOT start a frame.
REQ-016 START: SHALL sample rxs when the cycle counter reaches CLK_PER_BIT/2-1.
REQ-017 START: if the mid-bit sample is 1, SHALL treat it as a glitch, return to IDLE and not pulse rx_valid; if 0, SHALL go to DATA.
REQ-018 Every later sample SHALL occur CLK_PER_BIT cycles after the previous one (mid-bit).
REQ-019 DATA: SHALL shift in DATA_LENGTH samples LSB first, then go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-020 PARITY: SHALL compare one sample with the expected parity from REQ-007; a mismatch sets an internal parity flag.
REQ-021 STOP: SHALL sample one bit; a value of 0 sets frame error.
REQ-022 One cycle after the stop sample, SHALL load data_out, drive parity_err and frame_err for that frame, pulse rx_valid for exactly one cycle, and return to IDLE.
REQ-023 Data SHALL be delivered even when parity_err or frame_err is set.
REQ-024 parity_err and frame_err SHALL hold until the next rx_valid pulse; parity_err SHALL be 0 when PARITY_EN=0.
REQ-025 After a frame error with the line held low (break), SHALL remain in IDLE until a fresh falling edge follows a high level.
REQ-026 Back-to-back frames (next start bit immediately after the stop bit) SHALL be received with no lost frame.
REQ-027 The cycle counter SHALL be wide enough for CLK_PER_BIT-1 and wrap to 0 at each sample point; the bit counter SHALL be wide enough for DATA_LENGTH.

Reset
REQ-028 On rst=1 at a rx_clk edge, SHALL set: state to IDLE, data_out to 0, rx_valid to 0, parity_err to 0, frame_err to 0, rx_busy to 0, counters to 0, synchronizer flops to 1.
REQ-029 Reset mid-frame SHALL abandon the frame without an rx_valid pulse; reception restarts only on a new falling edge.

Structure
REQ-030 State encodings and default parameter values SHALL live in a shared package, uart_pkg, which is also used by the transmitter side.
REQ-031 Bit timing (cycle counter plus sample strobe) SHALL be one sub-module, baud_rate_RX, clocked by rx_clk and restarted by the receiver at start detection.

Verification (CLK_PER_BIT=20, DATA_LENGTH=8)
REQ-032 Frame 0x5A, PARITY_EN=0, valid stop bit -> data_out=0x5A, one rx_valid pulse about 192 cycles after the falling edge, no errors.
REQ-033 Frame 0xA5, PARITY_EN=1, parity_type=0, parity bit 0 -> parity_err=0; same frame with parity bit 1 -> parity_err=1, data_out=0xA5.
REQ-034 Frame 0x3C with stop bit 0 -> rx_valid pulses, frame_err=1, data_out=0x3C; line held low afterwards -> no further rx_valid.
REQ-035 Low pulse of 5 cycles on an idle line -> no rx_valid; state back in IDLE by cycle 12.
REQ-036 Frames 0x01 then 0xFF back-to-back -> two rx_valid pulses, 200 cycles apart, with the correct data each time.
REQ-037 rst asserted during data bit 4 -> all outputs take reset values next cycle, no rx_valid; next clean frame 0x77 -> received correctly.
